expansor_grupo: RTL and testbench



---
 rtl/expansor_grupo_if.sv | 34 +++
 rtl/expansor_grupo.sv | 180 ++++++++++++++++++
 tb/tb_expansor_grupo.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/expansor_grupo_if.sv
// -----------------------------------------------------------------------------
// expansor_grupo_if
// Request / stream bundle for the group expander.
//   start  : request pulse (requester -> expander)
//   g, c   : group code and class code, sampled with start
//   ready  : consumer accepts the current member this cycle
//   valid  : i holds a valid member value (expander -> consumer)
//   i      : current member value
//   last   : i is the final member of the group
//   busy   : a sequence is in progress
//   err    : one-cycle pulse, request rejected
// Modports: master = requester/consumer side, slave = expander side.
// -----------------------------------------------------------------------------
interface expansor_grupo_if;
    logic       start;
    logic [3:0] g;
    logic [3:0] c;
    logic       ready;
    logic       valid;
    logic [3:0] i;
    logic       last;
    logic       busy;
    logic       err;

    modport master (
        output start, g, c, ready,
        input  valid, i, last, busy, err
    );

    modport slave (
        input  start, g, c, ready,
        output valid, i, last, busy, err
    );
endinterface

// File: rtl/expansor_grupo.sv
// -----------------------------------------------------------------------------
// expansor_grupo
// Takes a group code g (1..3) and streams every 4-bit member of that group in
// ascending order, one member per valid/ready transfer.
//   g=1 -> G1_MIN..G2_MIN-1, g=2 -> G2_MIN..G3_MIN-1, g=3 -> G3_MIN..G3_MAX
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : expansor_grupo_if.slave (start, g, c, ready in; valid, i, last,
//           busy, err out). All outputs are registered.
// Optional feature macro: CHECK_C_EN
//   defined   : request also requires c == g + C_BASE
//   undefined : c is ignored, only g is validated
// -----------------------------------------------------------------------------
module expansor_grupo #(
    parameter int G1_MIN = 1,
    parameter int G2_MIN = 5,
    parameter int G3_MIN = 9,
    parameter int G3_MAX = 11,
    parameter int C_BASE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    expansor_grupo_if.slave   bus
);

    localparam logic [3:0] G1_LO  = 4'(G1_MIN);
    localparam logic [3:0] G1_HI  = 4'(G2_MIN - 1);
    localparam logic [3:0] G2_LO  = 4'(G2_MIN);
    localparam logic [3:0] G2_HI  = 4'(G3_MIN - 1);
    localparam logic [3:0] G3_LO  = 4'(G3_MIN);
    localparam logic [3:0] G3_HI  = 4'(G3_MAX);
`ifdef CHECK_C_EN
    localparam logic [3:0] C_OFS  = 4'(C_BASE);
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // First member of a group; unused codes map to zero.
    function automatic logic [3:0] grp_min(input logic [3:0] gv);
        case (gv)
            4'd1:    grp_min = G1_LO;
            4'd2:    grp_min = G2_LO;
            4'd3:    grp_min = G3_LO;
            default: grp_min = 4'd0;
        endcase
    endfunction

    // Last member of a group; unused codes map to zero.
    function automatic logic [3:0] grp_max(input logic [3:0] gv);
        case (gv)
            4'd1:    grp_max = G1_HI;
            4'd2:    grp_max = G2_HI;
            4'd3:    grp_max = G3_HI;
            default: grp_max = 4'd0;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [3:0] cur_q,   cur_d;
    logic [3:0] hi_q,    hi_d;
    logic       valid_q, valid_d;
    logic [3:0] i_q,     i_d;
    logic       last_q,  last_d;
    logic       busy_q,  busy_d;
    logic       err_q,   err_d;

    logic       g_ok_s;
    logic       req_ok_s;
    logic [3:0] nxt_s;

    // Request validation: group code range, plus class code when enabled.
    always_comb begin
        g_ok_s = (bus.g >= 4'd1) && (bus.g <= 4'd3);
`ifdef CHECK_C_EN
        req_ok_s = g_ok_s && (bus.c == (bus.g + C_OFS));
`else
        req_ok_s = g_ok_s;
`endif
    end

`ifndef CHECK_C_EN
    // c is part of the bus but has no function in this build.
    logic c_unused_s;
    assign c_unused_s = ^bus.c;
`endif

    assign nxt_s = cur_q + 4'd1;

    // Next-state and next-output computation for the IDLE/EMIT machine.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        hi_d    = hi_q;
        valid_d = valid_q;
        i_d     = i_q;
        last_d  = last_q;
        busy_d  = busy_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                last_d  = 1'b0;
                if (bus.start) begin
                    if (req_ok_s) begin
                        state_d = ST_EMIT;
                        cur_d   = grp_min(bus.g);
                        hi_d    = grp_max(bus.g);
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        i_d     = grp_min(bus.g);
                        last_d  = (grp_min(bus.g) == grp_max(bus.g));
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    err_d = 1'b0;
                end
            end
            ST_EMIT: begin
                if (valid_q && bus.ready) begin
                    if (last_q) begin
                        // Final transfer: i keeps the last member on the bus.
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        cur_d  = nxt_s;
                        i_d    = nxt_s;
                        last_d = (nxt_s == hi_q);
                    end
                end else begin
                    // Back-pressure: hold everything.
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cur_q   <= 4'd0;
            hi_q    <= 4'd0;
            valid_q <= 1'b0;
            i_q     <= 4'd0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            hi_q    <= hi_d;
            valid_q <= valid_d;
            i_q     <= i_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.valid = valid_q;
    assign bus.i     = i_q;
    assign bus.last  = last_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_expansor_grupo.sv
// -----------------------------------------------------------------------------
// tb_expansor_grupo
// Directed bench for expansor_grupo: reset values, full group streams,
// back-pressure, invalid requests, busy guard and asynchronous reset
// mid-sequence. Honours CHECK_C_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_expansor_grupo;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    expansor_grupo_if bus ();

    expansor_grupo dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare all outputs against a hand-computed expectation.
    task automatic chk(input string tag, input logic v, input logic [3:0] iv,
                       input logic l, input logic b, input logic e);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {bus.valid, bus.i, bus.last, bus.busy, bus.err};
        exp = {v, iv, l, b, e};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed valid=%b i=%0d last=%b busy=%b err=%b, expected valid=%b i=%0d last=%b busy=%b err=%b",
                   tag, obs[7], obs[6:3], obs[2], obs[1], obs[0], v, iv, l, b, e);
        end
    endtask

    task automatic req(input logic [3:0] gv, input logic [3:0] cv);
        bus.start = 1'b1;
        bus.g     = gv;
        bus.c     = cv;
    endtask

    // Directed stimulus sequence.
    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.g     = 4'd0;
        bus.c     = 4'd0;
        bus.ready = 1'b0;

        // Reset values.
        #1;
        chk("reset_t0", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        req(4'd1, 4'd9);
        tick();
        tick();
        chk("reset_held", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        tick();
        chk("reset_idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Group 1, ready held high.
        req(4'd1, 4'd9);
        bus.ready = 1'b1;
        tick();
        chk("g1_i1", 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
        bus.start = 1'b0;
        tick();
        chk("g1_i2", 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
        tick();
        chk("g1_i3", 1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
        tick();
        chk("g1_i4", 1'b1, 4'd4, 1'b1, 1'b1, 1'b0);
        tick();
        chk("g1_done", 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);

        // Group 3 with back-pressure: ready 1,0,0,1,1.
        req(4'd3, 4'd11);
        bus.ready = 1'b0;
        tick();
        chk("g3_i9", 1'b1, 4'd9, 1'b0, 1'b1, 1'b0);
        bus.start = 1'b0;
        bus.ready = 1'b1;
        tick();
        chk("g3_bp1", 1'b1, 4'd10, 1'b0, 1'b1, 1'b0);
        bus.ready = 1'b0;
        tick();
        chk("g3_bp2", 1'b1, 4'd10, 1'b0, 1'b1, 1'b0);
        tick();
        chk("g3_bp3", 1'b1, 4'd10, 1'b0, 1'b1, 1'b0);
        bus.ready = 1'b1;
        tick();
        chk("g3_bp4", 1'b1, 4'd11, 1'b1, 1'b1, 1'b0);
        tick();
        chk("g3_done", 1'b0, 4'd11, 1'b0, 1'b0, 1'b0);

        // Invalid group codes: one-cycle err pulse each.
        req(4'd0, 4'd8);
        tick();
        chk("bad_g0", 1'b0, 4'd11, 1'b0, 1'b0, 1'b1);
        bus.start = 1'b0;
        tick();
        chk("bad_g0_clr", 1'b0, 4'd11, 1'b0, 1'b0, 1'b0);
        req(4'd4, 4'd12);
        tick();
        chk("bad_g4", 1'b0, 4'd11, 1'b0, 1'b0, 1'b1);
        bus.start = 1'b0;
        tick();
        chk("bad_g4_clr", 1'b0, 4'd11, 1'b0, 1'b0, 1'b0);
        req(4'd15, 4'd7);
        tick();
        chk("bad_g15", 1'b0, 4'd11, 1'b0, 1'b0, 1'b1);
        bus.start = 1'b0;
        tick();
        chk("bad_g15_clr", 1'b0, 4'd11, 1'b0, 1'b0, 1'b0);

        // g=2 with mismatched c=9.
        req(4'd2, 4'd9);
        tick();
`ifdef CHECK_C_EN
        chk("c_mismatch_err", 1'b0, 4'd11, 1'b0, 1'b0, 1'b1);
        bus.start = 1'b0;
        tick();
        chk("c_mismatch_clr", 1'b0, 4'd11, 1'b0, 1'b0, 1'b0);
`else
        chk("c_ign_i5", 1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
        bus.start = 1'b0;
        tick();
        chk("c_ign_i6", 1'b1, 4'd6, 1'b0, 1'b1, 1'b0);
        tick();
        chk("c_ign_i7", 1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
        tick();
        chk("c_ign_i8", 1'b1, 4'd8, 1'b1, 1'b1, 1'b0);
        tick();
        chk("c_ign_done", 1'b0, 4'd8, 1'b0, 1'b0, 1'b0);
`endif

        // Busy guard: a new start at i=6 is ignored, no err.
        req(4'd2, 4'd10);
        tick();
        chk("busy_i5", 1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
        bus.start = 1'b0;
        tick();
        chk("busy_i6", 1'b1, 4'd6, 1'b0, 1'b1, 1'b0);
        req(4'd1, 4'd9);
        tick();
        chk("busy_i7", 1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
        bus.start = 1'b0;
        tick();
        chk("busy_i8", 1'b1, 4'd8, 1'b1, 1'b1, 1'b0);
        tick();
        chk("busy_fell", 1'b0, 4'd8, 1'b0, 1'b0, 1'b0);
        req(4'd1, 4'd9);
        tick();
        chk("restart_i1", 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        chk("restart_i4", 1'b1, 4'd4, 1'b1, 1'b1, 1'b0);
        tick();
        chk("restart_done", 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges while i=7.
        req(4'd2, 4'd10);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("pre_rst_i7", 1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("async_rst_hold", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        req(4'd2, 4'd10);
        tick();
        chk("post_rst_i5", 1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
        bus.start = 1'b0;
        tick();
        chk("post_rst_i6", 1'b1, 4'd6, 1'b0, 1'b1, 1'b0);
        tick();
        chk("post_rst_i7", 1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
        tick();
        chk("post_rst_i8", 1'b1, 4'd8, 1'b1, 1'b1, 1'b0);
        tick();
        chk("post_rst_done", 1'b0, 4'd8, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
